ram_ctrl: RTL and testbench

Command front-end for the 256x16 block RAM. Accepts single-word read/write commands over a valid/ready handshake, drives the RAM's registered write-enable/address/data inputs, and returns read data with a valid strobe after accounting for the RAM's one-cycle synchronous read. Also provides a hardware fill sequence that writes one value to every address. Sits directly upstream of the RAM and presents it to the rest of the design as a simple request/response port.

---
 rtl/ram_ctrl_if.sv | 58 +++++
 rtl/ram_ctrl.sv | 132 +++++++++++++
 tb/tb_ram_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_ctrl_if.sv
// Request/response and RAM-side signal bundle for ram_ctrl.
// slave is the controller view; master is the requester plus RAM view.
interface ram_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              fill_start;
    logic [DATA_W-1:0] fill_data;
    logic              busy;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  cmd_valid,
        input  cmd_write,
        input  cmd_addr,
        input  cmd_wdata,
        input  fill_start,
        input  fill_data,
        input  ram_dout,
        output cmd_ready,
        output busy,
        output rd_valid,
        output rd_data,
        output rd_addr,
        output ram_we,
        output ram_addr,
        output ram_din
    );

    modport master (
        output cmd_valid,
        output cmd_write,
        output cmd_addr,
        output cmd_wdata,
        output fill_start,
        output fill_data,
        output ram_dout,
        input  cmd_ready,
        input  busy,
        input  rd_valid,
        input  rd_data,
        input  rd_addr,
        input  ram_we,
        input  ram_addr,
        input  ram_din
    );
endinterface

// File: rtl/ram_ctrl.sv
// Command front-end for a synchronous-read block RAM with a hardware fill sweep.
// Read results return two edges after accept via a valid/address tag pipeline.
module ram_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    ram_ctrl_if.slave  bus
);
    typedef enum logic {
        S_IDLE,
        S_FILL
    } state_t;

    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_ram_we;
    logic              w_ram_we_nxt;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [ADDR_W-1:0] w_ram_addr_nxt;
    logic [DATA_W-1:0] r_ram_din;
    logic [DATA_W-1:0] w_ram_din_nxt;
    logic [ADDR_W:0]   r_fill_cnt;
    logic [ADDR_W:0]   w_fill_cnt_nxt;

    logic              w_cmd_ready;
    logic              w_accept;
    logic              w_rd_issue;

    logic              r_t1_v;
    logic [ADDR_W-1:0] r_t1_a;
    logic              r_t2_v;
    logic [ADDR_W-1:0] r_t2_a;

    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic [ADDR_W-1:0] r_rd_addr;

    // Fill wins over a command presented in the same cycle.
    assign w_cmd_ready = (r_state == S_IDLE) & ~bus.fill_start;
    assign w_accept    = bus.cmd_valid & w_cmd_ready;
    assign w_rd_issue  = w_accept & ~bus.cmd_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_fill_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ram_we   <= w_ram_we_nxt;
            r_ram_addr <= w_ram_addr_nxt;
            r_ram_din  <= w_ram_din_nxt;
            r_fill_cnt <= w_fill_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ram_we_nxt   = 1'b0;
        w_ram_addr_nxt = r_ram_addr;
        w_ram_din_nxt  = r_ram_din;
        w_fill_cnt_nxt = r_fill_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (bus.fill_start) begin
                    w_state_nxt    = S_FILL;
                    w_ram_we_nxt   = 1'b1;
                    w_ram_addr_nxt = '0;
                    w_ram_din_nxt  = bus.fill_data;
                    w_fill_cnt_nxt = CNT_ONE;
                end else if (w_accept) begin
                    w_ram_addr_nxt = bus.cmd_addr;
                    if (bus.cmd_write) begin
                        w_ram_we_nxt  = 1'b1;
                        w_ram_din_nxt = bus.cmd_wdata;
                    end
                end
            end
            S_FILL: begin
                // Extra counter bit flags that the last address has been issued.
                if (r_fill_cnt[ADDR_W]) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ram_we_nxt   = 1'b1;
                    w_ram_addr_nxt = r_fill_cnt[ADDR_W-1:0];
                    w_fill_cnt_nxt = r_fill_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_t1_v     <= 1'b0;
            r_t1_a     <= '0;
            r_t2_v     <= 1'b0;
            r_t2_a     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_addr  <= '0;
        end else begin
            r_t1_v     <= w_rd_issue;
            r_t1_a     <= bus.cmd_addr;
            r_t2_v     <= r_t1_v;
            r_t2_a     <= r_t1_a;
            r_rd_valid <= r_t2_v;
            if (r_t2_v) begin
                r_rd_data <= bus.ram_dout;
                r_rd_addr <= r_t2_a;
            end
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.busy      = (r_state == S_FILL);
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_din   = r_ram_din;
endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl with a behavioural 256x16 synchronous RAM.
// Reads push expectations; a negedge monitor pops them on rd_valid.
module tb_ram_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
        int          c;
    } exp_t;
    exp_t sb[$];

    logic [15:0] mem [256];

    ram_ctrl_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    ram_ctrl #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous read-first RAM model.
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.rd_valid) begin
            if (sb.size() == 0) begin
                chk("rd_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rd_data", 32'(bus.rd_data), 32'(e.d));
                chk("rd_addr", 32'(bus.rd_addr), 32'(e.a));
                chk("rd_latency", 32'(cyc), 32'(e.c + 2));
            end
        end
    end

    task automatic cmd(input bit wr, input logic [7:0] a,
                       input logic [15:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        #1;
        chk("cmd_ready", 32'(bus.cmd_ready), 32'd1);
        if (!wr) sb.push_back('{a, d, cyc + 1});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic start_fill(input logic [15:0] d, input bit with_cmd);
        bus.fill_start = 1'b1;
        bus.fill_data  = d;
        if (with_cmd) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_write = 1'b1;
            bus.cmd_addr  = 8'h77;
            bus.cmd_wdata = 16'hDEAD;
        end
        #1;
        chk("ready_vs_fill", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        bus.fill_start = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_write  = 1'b0;
    endtask

    task automatic run_fill(input bit pulse);
        int  nbusy = 0;
        int  nwe = 0;
        int  nseq = 0;
        int  ncov = 0;
        int  nrdy = 0;
        bit  seen [256];
        for (int k = 0; k < 256; k++) seen[k] = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!bus.busy) break;
            nbusy++;
            if (bus.cmd_ready) nrdy++;
            if (bus.ram_we) begin
                nwe++;
                seen[bus.ram_addr] = 1'b1;
                if (32'(bus.ram_addr) != (i & 255)) nseq++;
            end
            bus.fill_start = pulse && (i == 50);
            bus.fill_data  = 16'h3333;
            @(negedge clk);
        end
        bus.fill_start = 1'b0;
        for (int k = 0; k < 256; k++) if (seen[k]) ncov++;
        chk("busy_cycles", 32'(nbusy), 32'd256);
        chk("we_cycles", 32'(nwe), 32'd256);
        chk("fill_addr_seq", 32'(nseq), 32'd0);
        chk("fill_coverage", 32'(ncov), 32'd256);
        chk("ready_in_fill", 32'(nrdy), 32'd0);
        chk("we_after_fill", 32'(bus.ram_we), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
        chk({tag, "_rd_data"}, 32'(bus.rd_data), 32'd0);
        chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
        chk({tag, "_ram_we"}, 32'(bus.ram_we), 32'd0);
        chk({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
        chk({tag, "_ram_din"}, 32'(bus.ram_din), 32'd0);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
        bus.cmd_valid  = 1'b0;
        bus.cmd_write  = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_wdata  = '0;
        bus.fill_start = 1'b0;
        bus.fill_data  = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);

        // Write then read-after-write on consecutive accepts.
        cmd(1'b1, 8'h12, 16'hBEEF);
        cmd(1'b0, 8'h12, 16'hBEEF);
        idle(4);

        // Back-to-back writes then reads with valid held high.
        for (int i = 0; i < 8; i++) cmd(1'b1, 8'(i), 16'h1000 + 16'(i));
        for (int i = 0; i < 8; i++) cmd(1'b0, 8'(i), 16'h1000 + 16'(i));
        idle(4);

        // Read in flight when fill starts; also a fill_start pulse mid-fill.
        cmd(1'b1, 8'h30, 16'h0042);
        idle(1);
        cmd(1'b0, 8'h30, 16'h0042);
        bus.cmd_valid = 1'b0;
        start_fill(16'h1111, 1'b0);
        run_fill(1'b1);
        idle(1);
        cmd(1'b0, 8'h00, 16'h1111);
        cmd(1'b0, 8'h30, 16'h1111);
        cmd(1'b0, 8'hFF, 16'h1111);
        idle(4);

        // Reset after the edge that registers fill address 100.
        cmd(1'b1, 8'd200, 16'h2222);
        idle(1);
        start_fill(16'hA5A5, 1'b0);
        repeat (100) @(posedge clk);
        #1 reset = 1'b1;
        #1 chk_reset_vals("midfill");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        cmd(1'b0, 8'd0, 16'hA5A5);
        cmd(1'b0, 8'd99, 16'hA5A5);
        cmd(1'b0, 8'd100, 16'h1111);
        cmd(1'b0, 8'd200, 16'h2222);
        idle(4);

        // Fill and a write presented together: fill wins.
        start_fill(16'hA5A5, 1'b1);
        run_fill(1'b0);
        idle(1);
        cmd(1'b0, 8'h00, 16'hA5A5);
        cmd(1'b0, 8'h80, 16'hA5A5);
        cmd(1'b0, 8'hFF, 16'hA5A5);
        cmd(1'b0, 8'h77, 16'hA5A5);
        idle(10);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
